fetch_unit: RTL
===============

# fetch_unit

Front-end fetch stage that owns the program counter, drives byte addresses into `instructionMemory`, and captures the word that memory returns one cycle later. Captured words are buffered with their PCs in a small FIFO that feeds decode through a valid/ready handshake. Issue is throttled by FIFO credit. A branch/exception redirect flushes the queue, discards the in-flight fetch and restarts fetch at a new PC. Sits between `instructionMemory` and the decode/rename stage.

## Interface
- DEPTH, 4: FIFO entries (power of two, ≥2)
- RESET_PC, 32'h0: PC loaded at reset
- clk  in  1  clock; all state updates on posedge
- rstn  in  1  synchronous active-low reset
- imem_pc  out  32  byte address to instruction memory; equals internal pc_q
- imem_instr  in  32  word returned by memory; reflects the imem_pc sampled at the previous edge
- imem_stop  in  1  memory end-of-program flag, same timing as imem_instr
- redirect_valid  in  1  flush and restart request
- redirect_pc  in  32  restart address; bits [1:0] forced to 0
- dec_valid  out  1  FIFO head valid
- dec_instr  out  32  head instruction; 0 when dec_valid=0
- dec_pc  out  32  head PC; 0 when dec_valid=0
- dec_ready  in  1  decode accepts head this cycle
- fetch_done  out  1  end of program reached; no further issue

## Operation
- State: pc_q, inflight_q (an issue happened last cycle), inflight_pc_q, FIFO (DEPTH×64 bits, rd/wr pointers, count 0..DEPTH), done_q.
- issue = !redirect_valid && !done_q && (count + inflight_q) < DEPTH. Credit counts the in-flight word, so a push never meets a full FIFO.
- On issue: inflight_q<=1, inflight_pc_q<=pc_q, pc_q<=pc_q+4 (32-bit wrap, no saturation). Without issue: inflight_q<=0 and pc_q holds. Memory still samples the held address, and the returned word is ignored.
- Capture (inflight_q=1, no redirect): if imem_stop=0, push {inflight_pc_q, imem_instr}. If imem_stop=1, nothing is pushed and done_q<=1.
- pop = dec_valid && dec_ready. Push and pop in the same cycle leave count unchanged. There is no bypass: a push into an empty FIFO gives dec_valid on the next cycle.
- Redirect has priority over issue, push, pop and done:
  - count<=0, pointers<=0, inflight_q<=0, done_q<=0.
  - pc_q<={redirect_pc[31:2],2'b00}.
  - Head contents and any word returning that cycle are discarded, and no pop is counted.
- fetch_done = done_q. It stays asserted while the FIFO drains, and is cleared only by redirect or reset.

## Timing
- Reset (rstn=0 at posedge): pc_q=RESET_PC, inflight_q=0, count=0, done_q=0. Outputs: imem_pc=RESET_PC, dec_valid=0, dec_instr=0, dec_pc=0, fetch_done=0. Reset overrides redirect and anything in flight.
- Cycle 0 is the first cycle with rstn=1. Issue RESET_PC in cycle 0, capture in cycle 1, dec_valid=1 in cycle 2.
- Steady state with dec_ready=1: one instruction per cycle.
- Redirect in cycle N: imem_pc=redirect_pc in N+1 and dec_valid=0 in N+1. The first new instruction appears at dec in N+3.
- Full FIFO with dec_ready=0: imem_pc is stable and no words are lost. Issue resumes the cycle after a pop frees credit.

## Configuration
- FETCH_PERF_EN defined: adds two outputs, each cleared by reset only (not by redirect) and wrapping at 2^32:
  - perf_stall_cycles (out, 32): counts cycles where issue=0 because of credit.
  - perf_flushes (out, 32): counts redirect cycles.
- Undefined: these ports and their logic are absent, and behaviour is otherwise identical.

## Test plan
- Reset then sequential run: memory holds words W0..W7 at 0..28, dec_ready=1 → dec_pc 0,4,8,… one per cycle from cycle 2, with dec_instr matching.
- Backpressure: DEPTH=4, dec_ready=0 for 10 cycles → count reaches 4, imem_pc held at 16. After dec_ready=1, order is W0..W7 with no drop or duplicate.
- Redirect mid-stream: redirect_valid with redirect_pc=0x103 while the FIFO holds 3 entries → dec_valid=0 next cycle. The next dec_pc sequence is 0x100, 0x104, … and no stale PC appears.
- Redirect on a push-and-pop cycle: in-flight word and pop are both discarded, and count=0 the next cycle.
- End of program: run from 1008 → words at 1008, 1012, 1016 delivered. Then fetch_done=1 and no further dec_valid; a redirect to 0 clears fetch_done.
- FETCH_PERF_EN: 10-cycle stall → perf_stall_cycles=10 (or the exact credit-blocked cycle count). Two redirects → perf_flushes=2. Both read 0 after reset.

Source files
------------

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues to instruction memory, buffers returned words
// with their PCs for decode. Optional perf counters under FETCH_PERF_EN.
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        imem_stop,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        dec_ready,
  output logic        fetch_done
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flushes
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  fetch_entry_t      mem_q [DEPTH];
  fetch_entry_t      mem_d [DEPTH];
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic              done_q, done_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic [CW-1:0]     credit_used;
  logic              credit_full;
  logic              issue;
  logic              capture;
  logic              push;
  logic              pop;

  // The in-flight word holds a credit, so a capture can never find the FIFO full.
  always_comb begin
    credit_used = count_q + CW'(inflight_q);
    credit_full = (credit_used >= DEPTH_C);
    issue       = !redirect_valid && !done_q && !credit_full;
    capture     = inflight_q && !redirect_valid;
    push        = capture && !imem_stop;
    pop         = dec_valid && dec_ready && !redirect_valid;
  end

  assign imem_pc    = pc_q;
  assign fetch_done = done_q;
  assign dec_valid  = (count_q != '0);
  assign dec_instr  = dec_valid ? mem_q[rd_ptr_q].instr : 32'h0;
  assign dec_pc     = dec_valid ? mem_q[rd_ptr_q].pc    : 32'h0;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? pc_q : inflight_pc_q;
    done_d        = done_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    mem_d         = mem_q;
    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      done_d   = 1'b0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue)
        pc_d = pc_q + 32'd4;
      if (capture && imem_stop)
        done_d = 1'b1;
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: inflight_pc_q, instr: imem_instr};
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop)
        rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      done_q        <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      done_q        <= done_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q + 32'(!redirect_valid && !done_q && credit_full);
    perf_flush_d = perf_flush_q + 32'(redirect_valid);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flushes      = perf_flush_q;
`endif

endmodule
